// File: rtl/fp_addsub_unit.sv
// Multi-cycle IEEE-754 add/subtract, any EXP_W/MAN_W, all four rounding modes; define FADD_FTZ_EN to flush subnormals.
// valid_out rises 5 cycles after accept; result/flags held in DONE while ready_in=0, start ignored while busy.
module fp_addsub_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   op_sub,
    input  logic [1:0]             round_mode,
    input  logic                   start,
    input  logic                   ready_in,
    output logic                   ready_out,
    output logic                   valid_out,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
    state_t state, state_nxt;

    logic             sgn_a, sgn_b, nan_in, inf_a, inf_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W:0]   man_a, man_b;
    logic [1:0]       rm;
    logic             sgn_x, eff_sub;
    logic [EXP_W-1:0] exp_x;
    logic [XW-1:0]    sig_x, sig_y;
    logic [XW:0]      sum;
    logic [XW-1:0]    sig_n;
    logic [EXP_W:0]   exp_n;
    logic             zero_n;

    // Unpack: subnormals and zeros use exponent 1 with no hidden bit
    logic [EXP_W-1:0] ua_e, ub_e, ua_exp, ub_exp;
    logic [MAN_W-1:0] ua_f, ub_f;
    logic [MAN_W:0]   ua_man, ub_man;
    logic             ua_nan, ub_nan, ua_inf, ub_inf;
    always_comb begin
        ua_e   = op_a[MAN_W +: EXP_W];
        ub_e   = op_b[MAN_W +: EXP_W];
        ua_f   = op_a[MAN_W-1:0];
        ub_f   = op_b[MAN_W-1:0];
        ua_nan = (ua_e == EXP_ONES) && (ua_f != '0);
        ub_nan = (ub_e == EXP_ONES) && (ub_f != '0);
        ua_inf = (ua_e == EXP_ONES) && (ua_f == '0);
        ub_inf = (ub_e == EXP_ONES) && (ub_f == '0);
        ua_exp = (ua_e == '0) ? EXP_W'(1) : ua_e;
        ub_exp = (ub_e == '0) ? EXP_W'(1) : ub_e;
`ifdef FADD_FTZ_EN
        ua_man = (ua_e == '0) ? '0 : {1'b1, ua_f};
        ub_man = (ub_e == '0) ? '0 : {1'b1, ub_f};
`else
        ua_man = {(ua_e != '0), ua_f};
        ub_man = {(ub_e != '0), ub_f};
`endif
    end

    logic             swap;
    logic [EXP_W-1:0] al_ex, al_ey;
    logic [MAN_W:0]   al_mx, al_my;
    logic [XW-1:0]    al_y_ext, al_y_sh, al_mask;
    int               al_d;
    always_comb begin
        swap     = {exp_b, man_b} > {exp_a, man_a};
        al_ex    = swap ? exp_b : exp_a;
        al_ey    = swap ? exp_a : exp_b;
        al_mx    = swap ? man_b : man_a;
        al_my    = swap ? man_a : man_b;
        al_d     = int'(al_ex) - int'(al_ey);
        if (al_d > MAN_W + 3) al_d = MAN_W + 3;
        al_y_ext = {al_my, 3'b000};
        al_mask  = ~({XW{1'b1}} << al_d);
        al_y_sh  = al_y_ext >> al_d;
        al_y_sh[0] = al_y_sh[0] | (|(al_y_ext & al_mask));
    end

    int             nm_lz, nm_sh;
    logic [XW-1:0]  nm_sig;
    logic [EXP_W:0] nm_exp;
    always_comb begin
        nm_lz = XW;
        for (int i = 0; i < XW; i++) if (sum[i]) nm_lz = XW - 1 - i;
        nm_sh = int'(exp_x) - 1;
        if (nm_lz < nm_sh) nm_sh = nm_lz;
        nm_sig = sum[XW-1:0] << nm_sh;
        nm_exp = {1'b0, exp_x} - (EXP_W+1)'(nm_sh);
        if (sum[XW]) begin
            nm_sig = {sum[XW:2], sum[1] | sum[0]};
            nm_exp = {1'b0, exp_x} + (EXP_W+1)'(1);
        end
    end

    logic [MAN_W:0]   rd_mant;
    logic [MAN_W+1:0] rd_sum;
    logic [MAN_W-1:0] rd_frac;
    logic [EXP_W:0]   rd_exp;
    logic             rd_g, rd_r, rd_s, rd_inexact, rd_up, rd_ovf, rd_inf_sel;
    logic [W-1:0]     rd_res;
    logic [4:0]       rd_flags;
    always_comb begin
        rd_mant    = sig_n[XW-1:3];
        rd_g       = sig_n[2];
        rd_r       = sig_n[1];
        rd_s       = sig_n[0];
        rd_inexact = rd_g | rd_r | rd_s;
        case (rm)
            2'b00:   rd_up = rd_g & (rd_r | rd_s | rd_mant[0]);
            2'b01:   rd_up = 1'b0;
            2'b10:   rd_up = ~sgn_x & rd_inexact;
            default: rd_up = sgn_x & rd_inexact;
        endcase
        rd_sum  = {1'b0, rd_mant} + (MAN_W+2)'(rd_up);
        rd_frac = rd_sum[MAN_W-1:0];
        // A subnormal that rounds into the hidden bit already carries exponent 1
        rd_exp  = rd_sum[MAN_W] ? exp_n : '0;
        if (rd_sum[MAN_W+1]) begin
            rd_frac = rd_sum[MAN_W:1];
            rd_exp  = exp_n + (EXP_W+1)'(1);
        end
        rd_ovf     = rd_exp >= {1'b0, EXP_ONES};
        rd_inf_sel = (rm == 2'b00) | ((rm == 2'b10) & ~sgn_x) | ((rm == 2'b11) & sgn_x);
        rd_res     = {sgn_x, rd_exp[EXP_W-1:0], rd_frac};
        rd_flags   = {rd_inexact, 1'b0, 1'b0, (rd_exp == '0) & rd_inexact, 1'b0};
        if (rd_ovf) begin
            rd_res   = rd_inf_sel ? {sgn_x, EXP_ONES, {MAN_W{1'b0}}}
                                  : {sgn_x, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
            rd_flags = 5'b10100;
        end
`ifdef FADD_FTZ_EN
        else if ((rd_exp == '0) && (rd_frac != '0)) begin
            rd_res   = {sgn_x, {(W-1){1'b0}}};
            rd_flags = 5'b10010;
        end
`endif
        if (zero_n) begin
            rd_res   = {(eff_sub ? (rm == 2'b11) : sgn_x), {(W-1){1'b0}}};
            rd_flags = '0;
        end
        if (nan_in | (inf_a & inf_b & (sgn_a ^ sgn_b))) begin
            rd_res   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            rd_flags = 5'b00001;
        end else if (inf_a | inf_b) begin
            rd_res   = {(inf_a ? sgn_a : sgn_b), EXP_ONES, {MAN_W{1'b0}}};
            rd_flags = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ALIGN;
            S_ALIGN: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM:  state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_DONE;
            S_DONE:  if (ready_in) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state == S_IDLE);
        valid_out = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_a <= 1'b0; sgn_b <= 1'b0; nan_in <= 1'b0; inf_a <= 1'b0; inf_b <= 1'b0;
            exp_a <= '0; exp_b <= '0; man_a <= '0; man_b <= '0; rm <= '0;
            sgn_x <= 1'b0; eff_sub <= 1'b0; exp_x <= '0; sig_x <= '0; sig_y <= '0;
            sum <= '0; sig_n <= '0; exp_n <= '0; zero_n <= 1'b0;
            result <= '0; flags <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sgn_a  <= op_a[W-1];
                    sgn_b  <= op_b[W-1] ^ op_sub;
                    exp_a  <= ua_exp;
                    exp_b  <= ub_exp;
                    man_a  <= ua_man;
                    man_b  <= ub_man;
                    nan_in <= ua_nan | ub_nan;
                    inf_a  <= ua_inf;
                    inf_b  <= ub_inf;
                    rm     <= round_mode;
                end
                S_ALIGN: begin
                    sgn_x   <= swap ? sgn_b : sgn_a;
                    eff_sub <= sgn_a ^ sgn_b;
                    exp_x   <= al_ex;
                    sig_x   <= {al_mx, 3'b000};
                    sig_y   <= al_y_sh;
                end
                S_ADD: sum <= eff_sub ? ({1'b0, sig_x} - {1'b0, sig_y})
                                      : ({1'b0, sig_x} + {1'b0, sig_y});
                S_NORM: begin
                    sig_n  <= nm_sig;
                    exp_n  <= nm_exp;
                    zero_n <= (sum == '0);
                end
                S_ROUND: begin
                    result <= rd_res;
                    flags  <= rd_flags;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed bench for fp_addsub_unit (single precision) with an expected-result queue.
module tb_fp_addsub_unit;
    logic        clk = 1'b0;
    logic        rst_n, op_sub, start, ready_in, ready_out, valid_out;
    logic [31:0] op_a, op_b, result;
    logic [1:0]  round_mode;
    logic [4:0]  flags;
    logic [36:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    fp_addsub_unit dut (
        .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .round_mode(round_mode), .start(start), .ready_in(ready_in),
        .ready_out(ready_out), .valid_out(valid_out), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [1:0] rm, input logic [31:0] er,
                          input logic [4:0] ef, input bit hold);
        logic [36:0] want;
        int          cyc;
        cyc = 0;
        while (ready_out !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_idle"}, {36'd0, ready_out}, 37'd1);
        op_a = a; op_b = b; op_sub = sub; round_mode = rm; start = 1'b1;
        ready_in = hold ? 1'b0 : 1'b1;
        exp_q.push_back({er, ef});
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; op_sub = ~sub; round_mode = ~rm;
        cyc = 1;
        while (valid_out !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 37'(cyc), 37'd5);
        want = exp_q.pop_front();
        chk({tag, "_res"}, {result, flags}, want);
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                start = 1'b1; op_a = $urandom; op_b = $urandom;
                @(negedge clk);
                chk({tag, "_hold_res"}, {result, flags}, want);
                chk({tag, "_hold_hs"}, {35'd0, valid_out, ready_out}, 37'b10);
            end
            start = 1'b0;
            ready_in = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_ret"}, {35'd0, valid_out, ready_out}, 37'b01);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; ready_in = 1'b1; op_sub = 1'b0; round_mode = 2'b00;
        op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {36'd0, ready_out}, 37'd1);
        chk("rst_valid", {36'd0, valid_out}, 37'd0);
        chk("rst_result", {5'd0, result}, 37'd0);
        chk("rst_flags", {32'd0, flags}, 37'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sub_basic", 32'h41A60000, 32'h40100000, 1'b1, 2'b00, 32'h41940000, 5'b00000, 1'b0);
        run_op("sub_cancel", 32'h3DCCCCCD, 32'h3E4CCCCD, 1'b1, 2'b00, 32'hBDCCCCCD, 5'b00000, 1'b0);
        run_op("rne_tie", 32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 5'b10000, 1'b0);
        run_op("rup_tie", 32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001, 5'b10000, 1'b0);
        run_op("rdn_neg", 32'hBF800000, 32'hB3800000, 1'b0, 2'b11, 32'hBF800001, 5'b10000, 1'b0);
        run_op("rnd_carry", 32'h3F7FFFFF, 32'h33000000, 1'b0, 2'b00, 32'h3F800000, 5'b10000, 1'b0);
        run_op("ovf_rtz", 32'hFF69999A, 32'h7F69999A, 1'b1, 2'b01, 32'hFF7FFFFF, 5'b10100, 1'b0);
        run_op("ovf_rne", 32'hFF69999A, 32'h7F69999A, 1'b1, 2'b00, 32'hFF800000, 5'b10100, 1'b0);
        run_op("ovf_rup", 32'hFF69999A, 32'h7F69999A, 1'b1, 2'b10, 32'hFF7FFFFF, 5'b10100, 1'b0);
        run_op("inf_inf", 32'hFF800000, 32'hFF800000, 1'b1, 2'b00, 32'h7FC00000, 5'b00001, 1'b0);
        run_op("nan_in", 32'h7FC00000, 32'hC18828F6, 1'b1, 2'b00, 32'h7FC00000, 5'b00001, 1'b0);
        run_op("inf_fin", 32'h7F800000, 32'h3F800000, 1'b0, 2'b00, 32'h7F800000, 5'b00000, 1'b0);
        run_op("pz_mz", 32'h00000000, 32'h80000000, 1'b1, 2'b00, 32'h00000000, 5'b00000, 1'b0);
        run_op("mz_mz", 32'h80000000, 32'h80000000, 1'b0, 2'b00, 32'h80000000, 5'b00000, 1'b0);
        run_op("rdn_zero", 32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 32'h80000000, 5'b00000, 1'b0);
`ifdef FADD_FTZ_EN
        run_op("sub_in", 32'h00000040, 32'h00000003, 1'b1, 2'b00, 32'h00000000, 5'b00000, 1'b0);
        run_op("sub_out", 32'h00800001, 32'h00800000, 1'b1, 2'b00, 32'h00000000, 5'b10010, 1'b0);
`else
        run_op("sub_in", 32'h00000040, 32'h00000003, 1'b1, 2'b00, 32'h0000003D, 5'b00000, 1'b0);
        run_op("sub_out", 32'h00800001, 32'h00800000, 1'b1, 2'b00, 32'h00000001, 5'b00000, 1'b0);
`endif
        run_op("hold", 32'h41A60000, 32'h40100000, 1'b1, 2'b00, 32'h41940000, 5'b00000, 1'b1);

        // Abort an operation in the ADD state with an asynchronous reset pulse
        op_a = 32'h3F800000; op_b = 32'h40000000; op_sub = 1'b0; round_mode = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_hs", {35'd0, valid_out, ready_out}, 37'b01);
        chk("mid_rst_out", {result, flags}, 37'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_out !== 1'b0) cyc++;
        end
        chk("mid_rst_novalid", 37'(cyc), 37'd0);
        chk("sb_empty", 37'(exp_q.size()), 37'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
